// File: rtl/stats_pkg.sv
// Shared types and constants for the stats report serialiser.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: FSM state encoding, stat snapshot struct, ASCII constants, frame
// lengths for both builds, and the nibble-to-hex / field-tag helpers.
// Build option: STATS_REPORT_CHECKSUM_EN selects the 28-byte checksummed frame.
package stats_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    // Field order matches the order the fields appear on the wire.
    typedef struct packed {
        logic [3:0] hunger;
        logic [4:0] happiness;
        logic [3:0] health;
        logic [3:0] hygiene;
        logic [3:0] energy;
        logic [3:0] social;
    } stats_t;

    localparam logic [7:0] TAG_HUNGER    = 8'h55; // 'U'
    localparam logic [7:0] TAG_HAPPINESS = 8'h41; // 'A'
    localparam logic [7:0] TAG_HEALTH    = 8'h48; // 'H'
    localparam logic [7:0] TAG_HYGIENE   = 8'h59; // 'Y'
    localparam logic [7:0] TAG_ENERGY    = 8'h45; // 'E'
    localparam logic [7:0] TAG_SOCIAL    = 8'h53; // 'S'

    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    localparam int FRAME_LEN_PLAIN = 25;
    localparam int FRAME_LEN_CSUM  = 28;
`ifdef STATS_REPORT_CHECKSUM_EN
    localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
    localparam int FRAME_LEN = FRAME_LEN_PLAIN;
`endif

    // Bytes 0..22 are the six "<tag><hh>" fields plus separators.
    localparam logic [4:0] FIELDS_END = 5'd23;

    function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] tag_char(input logic [2:0] field);
        case (field)
            3'd0:    return TAG_HUNGER;
            3'd1:    return TAG_HAPPINESS;
            3'd2:    return TAG_HEALTH;
            3'd3:    return TAG_HYGIENE;
            3'd4:    return TAG_ENERGY;
            default: return TAG_SOCIAL;
        endcase
    endfunction

endpackage

// File: rtl/hex_ascii.sv
// Nibble to uppercase ASCII hex digit ('0'-'9', 'A'-'F').
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: nibble (4-bit value in), ascii (8-bit character out).
module hex_ascii
    import stats_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    assign ascii = nibble_to_hex(nibble);

endmodule

// File: rtl/stats_reporter.sv
// Snapshots the six pet stats and streams them as one ASCII frame to a UART TX.
// Latency: trigger sampled on edge N -> byte 0 valid after edge N+2; one byte per cycle.
// Backpressure: tx_valid/tx_ready; byte held while stalled, no bubbles between bytes.
// Ports: clk, reset (async, active-high), second (toggle events), request (pulse),
//   hunger/happiness/health/hygiene/energy/social (stats in), tx_data/tx_valid/
//   tx_ready (byte stream out), busy (frame loading or sending).
// Build option: STATS_REPORT_CHECKSUM_EN appends "*<hh>" (XOR of bytes 0..22).
module stats_reporter
    import stats_pkg::*;
#(
    parameter int PERIOD_DIV = 1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       second,
    input  logic       request,
    input  logic [3:0] hunger,
    input  logic [4:0] happiness,
    input  logic [3:0] health,
    input  logic [3:0] hygiene,
    input  logic [3:0] energy,
    input  logic [3:0] social,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy
);

    localparam bit         AUTO_EN  = (PERIOD_DIV > 0);
    localparam logic [3:0] DIV_LAST = AUTO_EN ? 4'(PERIOD_DIV - 1) : 4'd0;
    localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);

    state_t     state, state_nxt;
    logic       second_q;
    logic [3:0] divider;
    logic       pending;
    stats_t     snap;
    logic [4:0] idx;         // next byte to move into the output register
    logic       all_loaded;  // last byte of the frame is in the output register
    logic       toggle, div_fire, trigger;
    logic       load_slot, last_xfer;
    logic [7:0] field_val, cur_byte, hex_char;
    logic [3:0] nibble;

    assign toggle    = second ^ second_q;
    assign div_fire  = AUTO_EN && toggle && (divider == DIV_LAST);
    assign trigger   = request | div_fire;
    assign busy      = (state != ST_IDLE);

    // The output register refills whenever it is empty or being drained this
    // cycle, which is what keeps the stream free of bubbles.
    assign load_slot = (state == ST_SEND) && (!tx_valid || tx_ready) && !all_loaded;
    assign last_xfer = (state == ST_SEND) && tx_valid && tx_ready && all_loaded;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            second_q <= 1'b0;
            divider  <= 4'd0;
            pending  <= 1'b0;
        end else begin
            second_q <= second;
            if (AUTO_EN && toggle)
                divider <= div_fire ? 4'd0 : divider + 4'd1;
            // One queued frame at most; triggers while one is queued are lost.
            if (last_xfer && pending)
                pending <= 1'b0;
            else if (busy && trigger)
                pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (trigger) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_SEND;
            ST_SEND: if (last_xfer) state_nxt = pending ? ST_LOAD : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap       <= '0;
            idx        <= 5'd0;
            all_loaded <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            if (state == ST_LOAD) begin
                snap       <= {hunger, happiness, health, hygiene, energy, social};
                idx        <= 5'd0;
                all_loaded <= 1'b0;
            end
            if (load_slot) begin
                tx_data  <= cur_byte;
                tx_valid <= 1'b1;
                if (idx == LAST_IDX)
                    all_loaded <= 1'b1;
                else
                    idx <= idx + 5'd1;
            end else if (last_xfer) begin
                tx_valid <= 1'b0;
            end
        end
    end

`ifdef STATS_REPORT_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR of the field bytes as they enter the output register; it is
    // complete by the time the checksum digits are fetched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            csum <= 8'h00;
        else if (state == ST_LOAD)
            csum <= 8'h00;
        else if (load_slot && (idx < FIELDS_END))
            csum <= csum ^ cur_byte;
    end
`endif

    // Field bytes come in groups of four: tag, high digit, low digit, comma.
    always_comb begin
        field_val = 8'h00;
        case (idx[4:2])
            3'd0:    field_val = {4'h0, snap.hunger};
            3'd1:    field_val = {3'h0, snap.happiness};
            3'd2:    field_val = {4'h0, snap.health};
            3'd3:    field_val = {4'h0, snap.hygiene};
            3'd4:    field_val = {4'h0, snap.energy};
            3'd5:    field_val = {4'h0, snap.social};
            default: field_val = 8'h00;
        endcase
        nibble = idx[0] ? field_val[7:4] : field_val[3:0];
`ifdef STATS_REPORT_CHECKSUM_EN
        if (idx == 5'd24)
            nibble = csum[7:4];
        else if (idx == 5'd25)
            nibble = csum[3:0];
`endif
    end

    hex_ascii u_hex (
        .nibble (nibble),
        .ascii  (hex_char)
    );

    always_comb begin
        cur_byte = CH_LF;
        if (idx < FIELDS_END) begin
            case (idx[1:0])
                2'd0:    cur_byte = tag_char(idx[4:2]);
                2'd1,
                2'd2:    cur_byte = hex_char;
                default: cur_byte = CH_COMMA;
            endcase
        end else begin
`ifdef STATS_REPORT_CHECKSUM_EN
            case (idx)
                5'd23:   cur_byte = CH_STAR;
                5'd24,
                5'd25:   cur_byte = hex_char;
                5'd26:   cur_byte = CH_CR;
                default: cur_byte = CH_LF;
            endcase
`else
            cur_byte = (idx == 5'd23) ? CH_CR : CH_LF;
`endif
        end
    end

endmodule

// File: tb/tb_stats_reporter.sv
// Bench for stats_reporter: random stats and stalls, scoreboard of expected bytes
// built from the frame format, monitor compares every accepted byte.
module tb_stats_reporter;

`ifdef STATS_REPORT_CHECKSUM_EN
    localparam int FLEN = 28;
`else
    localparam int FLEN = 25;
`endif

    logic       clk = 1'b0;
    logic       reset, second, request, tx_ready;
    logic [3:0] hunger, health, hygiene, energy, social;
    logic [4:0] happiness;
    logic [7:0] tx_data, tx_data0;
    logic       tx_valid, tx_valid0, busy, busy0;

    always #5 clk = ~clk;

    stats_reporter #(.PERIOD_DIV(3)) dut (
        .clk(clk), .reset(reset), .second(second), .request(request),
        .hunger(hunger), .happiness(happiness), .health(health),
        .hygiene(hygiene), .energy(energy), .social(social),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
    );

    stats_reporter #(.PERIOD_DIV(0)) dut0 (
        .clk(clk), .reset(reset), .second(second), .request(request),
        .hunger(hunger), .happiness(happiness), .health(health),
        .hygiene(hygiene), .energy(energy), .social(social),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready), .busy(busy0)
    );

    int         checks = 0, errors = 0;
    int         frames = 0, frames0 = 0, frame_pos = 0;
    int         cyc = 0, last_lf_cyc = 0, last_gap = 0;
    bit         lf_seen = 1'b0, prev_valid = 1'b0, stall_pend = 1'b0;
    bit         rnd_ready = 1'b0;
    logic [7:0] held_data = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] cap[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    // Reference frame: "<tag><hh>," x6 (no trailing comma), optional "*<hh>", CR LF.
    task automatic push_frame(input logic [3:0] u, input logic [4:0] a, input logic [3:0] h,
                              input logic [3:0] y, input logic [3:0] e, input logic [3:0] s);
        logic [7:0] v [6];
        logic [7:0] fr[$];
        string      tg;
        tg = "UAHYES";
        v[0] = {4'h0, u}; v[1] = {3'h0, a}; v[2] = {4'h0, h};
        v[3] = {4'h0, y}; v[4] = {4'h0, e}; v[5] = {4'h0, s};
        for (int f = 0; f < 6; f++) begin
            fr.push_back(tg[f]);
            fr.push_back(hexc(v[f][7:4]));
            fr.push_back(hexc(v[f][3:0]));
            if (f < 5) fr.push_back(8'h2C);
        end
`ifdef STATS_REPORT_CHECKSUM_EN
        begin
            logic [7:0] cs;
            cs = 8'h00;
            foreach (fr[i]) cs = cs ^ fr[i];
            fr.push_back(8'h2A);
            fr.push_back(hexc(cs[7:4]));
            fr.push_back(hexc(cs[3:0]));
        end
`endif
        fr.push_back(8'h0D);
        fr.push_back(8'h0A);
        foreach (fr[i]) exp_q.push_back(fr[i]);
    endtask

    task automatic push_current;
        push_frame(hunger, happiness, health, hygiene, energy, social);
    endtask

    task automatic randomize_stats;
        hunger    = 4'($urandom_range(0, 15));
        happiness = 5'($urandom_range(0, 31));
        health    = 4'($urandom_range(0, 15));
        hygiene   = 4'($urandom_range(0, 15));
        energy    = 4'($urandom_range(0, 15));
        social    = 4'($urandom_range(0, 15));
    endtask

    task automatic do_request;
        request = 1'b1;
        tick();
        request = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || tx_valid) && n < budget) begin
            tick();
            n++;
        end
        chk(name, int'(n < budget), 1);
        tick();
    endtask

    always @(posedge clk) cyc++;

    // Monitor: every accepted byte is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (reset) begin
            frame_pos  = 0;
            stall_pend = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (tx_valid && !prev_valid && lf_seen)
                last_gap = cyc - last_lf_cyc;
            if (stall_pend) begin
                chk("stall_hold_valid", int'(tx_valid), 1);
                chk("stall_hold_data", int'(tx_data), int'(held_data));
            end
            if (tx_valid && tx_ready) begin
                cap.push_back(tx_data);
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", int'(tx_data), -1);
                end else begin
                    chk("frame_byte", int'(tx_data), int'(exp_q.pop_front()));
                end
                frame_pos++;
                if (tx_data == 8'h0A) begin
                    frames++;
                    frame_pos   = 0;
                    lf_seen     = 1'b1;
                    last_lf_cyc = cyc;
                end
            end
            if (tx_valid0 && tx_ready && tx_data0 == 8'h0A) frames0++;
            stall_pend = tx_valid && !tx_ready;
            held_data  = tx_data;
            prev_valid = tx_valid;
        end
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    f0, g0, n, bad, idle_v;
        string lit;

        // Reset state and a quiet idle period
        reset = 1'b1; second = 1'b0; request = 1'b0;
        randomize_stats();
        repeat (3) tick();
        chk("rst_tx_valid", int'(tx_valid), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        idle_v = 0;
        repeat (100) begin
            tick();
            if (tx_valid || busy) idle_v++;
        end
        chk("idle_activity", idle_v, 0);
        chk("idle_frames", frames, 0);

        // Known frame, latency and busy timing
        hunger = 4'd3; happiness = 5'h12; health = 4'd15;
        hygiene = 4'd0; energy = 4'd7; social = 4'd10;
        cap.delete();
        push_current();
        f0 = frames;
        do_request();
        chk("lat_busy_load", int'(busy), 1);
        chk("lat_valid_n1", int'(tx_valid), 0);
        tick();
        chk("lat_valid_n2", int'(tx_valid), 0);
        tick();
        chk("lat_valid_n3", int'(tx_valid), 1);
        chk("lat_first_byte", int'(tx_data), 85);
        n = 0;
        while (frames == f0 && n < 100) begin tick(); n++; end
        chk("lf_seen_in_time", int'(n < 100), 1);
        chk("busy_after_lf", int'(busy), 0);
        wait_idle("known_frame_drain", 100);
`ifdef STATS_REPORT_CHECKSUM_EN
        lit = "U03,A12,H0F,Y00,E07,S0A*3F\r\n";
`else
        lit = "U03,A12,H0F,Y00,E07,S0A\r\n";
`endif
        chk("known_frame_len", cap.size(), FLEN);
        if (cap.size() == FLEN) begin
            bad = 0;
            for (int i = 0; i < FLEN; i++)
                if (cap[i] != lit[i]) bad++;
            chk("known_frame_text", bad, 0);
        end

        // Random stalls with stats changing after the snapshot
        rnd_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            randomize_stats();
            push_current();
            do_request();
            tick();
            randomize_stats();
            repeat ($urandom_range(2, 12)) begin
                tick();
                randomize_stats();
            end
            wait_idle("stall_frame_drain", 600);
        end
        rnd_ready = 1'b0;

        // Three extra requests during one frame: one queued, two dropped
        randomize_stats();
        f0 = frames;
        push_current();
        do_request();
        repeat (5) tick();
        do_request();
        push_current();
        repeat (5) tick();
        do_request();
        repeat (5) tick();
        do_request();
        wait_idle("pending_drain", 300);
        chk("pending_frame_count", frames - f0, 2);
        chk("pending_gap_cycles", last_gap, 3);

        // Auto reports every third toggle; PERIOD_DIV=0 instance stays silent
        reset = 1'b1;
        tick();
        chk("rst2_busy", int'(busy), 0);
        reset = 1'b0;
        tick();
        randomize_stats();
        f0 = frames;
        g0 = frames0;
        for (int t = 1; t <= 9; t++) begin
            second = ~second;
            if (t % 3 == 0) push_current();
            repeat (40) tick();
        end
        wait_idle("auto_drain", 200);
        chk("auto_frame_count", frames - f0, 3);
        chk("div0_frame_count", frames0 - g0, 0);
        chk("div0_busy", int'(busy0), 0);

        // Reset in the middle of a frame, then a clean restart
        randomize_stats();
        push_current();
        do_request();
        n = 0;
        while (frame_pos != 10 && n < 200) begin tick(); n++; end
        chk("reached_byte10", int'(n < 200), 1);
        reset = 1'b1;
        #1;
        chk("midrst_tx_valid", int'(tx_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        cap.delete();
        randomize_stats();
        push_current();
        do_request();
        wait_idle("restart_drain", 200);
        chk("restart_len", cap.size(), FLEN);
        if (cap.size() > 0) chk("restart_first", int'(cap[0]), 85);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
